// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch digit counters.
package stopwatch_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  localparam int SEC_LO_MOD = 10;
  localparam int SEC_HI_MOD = 6;

  // Out-of-range presets snap to the largest legal digit value.
  function automatic int unsigned clamp_to_mod(input int unsigned value,
                                               input int unsigned modulus);
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// Single modulo-MOD digit with clear/load/step and a carry/borrow wrap-out.
module mod_digit
  import stopwatch_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = SEC_LO_MOD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

  assign wrap = (inc && (value == MAX_VAL)) || (dec && (value == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value == MAX_VAL) ? '0 : value + 1'b1;
    end else if (dec) begin
      value <= (value == '0) ? MAX_VAL : value - 1'b1;
    end
  end

endmodule

// File: rtl/time_counter_gen.sv
// Two-digit modulo time counter with run/stop FSM, up/down count and
// wrap-or-saturate behaviour at the bounds; ovf chains to the next stage.
module time_counter_gen
  import stopwatch_pkg::*;
#(
  parameter int HI_W     = 3,
  parameter int LO_W     = 4,
  parameter int HI_MOD   = SEC_HI_MOD,
  parameter int LO_MOD   = SEC_LO_MOD,
  parameter bit SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            back,
  input  logic            run_toggle,
  input  logic            clear,
  input  logic            load,
  input  logic [HI_W-1:0] load_high,
  input  logic [LO_W-1:0] load_low,
  output logic [HI_W-1:0] high_val,
  output logic [LO_W-1:0] low_val,
  output logic            ovf,
  output logic            running
);

  run_state_t      state, state_next;
  logic            count_en;
  logic            at_top, at_bottom, at_bound;
  logic            sat_stop;
  logic            lo_inc, lo_dec, lo_wrap;
  logic            hi_inc, hi_dec, hi_wrap;
  logic [HI_W-1:0] load_high_c;
  logic [LO_W-1:0] load_low_c;

  assign load_high_c = HI_W'(clamp_to_mod(32'(load_high), HI_MOD));
  assign load_low_c  = LO_W'(clamp_to_mod(32'(load_low), LO_MOD));

  assign count_en  = tick && (state == RUN) && !clear && !load;
  assign at_top    = (high_val == HI_W'(HI_MOD - 1)) && (low_val == LO_W'(LO_MOD - 1));
  assign at_bottom = (high_val == '0) && (low_val == '0);
  assign at_bound  = back ? at_bottom : at_top;
  assign sat_stop  = SATURATE && count_en && at_bound;

  // In saturate mode the bound tick is swallowed here, so the digits never move.
  assign lo_inc = count_en && !back && !sat_stop;
  assign lo_dec = count_en &&  back && !sat_stop;
  assign hi_inc = lo_wrap && !back;
  assign hi_dec = lo_wrap &&  back;

  mod_digit #(.W(LO_W), .MOD(LO_MOD)) u_low (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (load),
    .load_val (load_low_c),
    .inc      (lo_inc),
    .dec      (lo_dec),
    .value    (low_val),
    .wrap     (lo_wrap)
  );

  mod_digit #(.W(HI_W), .MOD(HI_MOD)) u_high (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (load),
    .load_val (load_high_c),
    .inc      (hi_inc),
    .dec      (hi_dec),
    .value    (high_val),
    .wrap     (hi_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= STOP;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      ovf   <= sat_stop || hi_wrap;
    end
  end

  // Saturation stop overrides a coincident run_toggle.
  always_comb begin
    state_next = state;
    if (run_toggle) begin
      state_next = (state == RUN) ? STOP : RUN;
    end
    if (sat_stop) begin
      state_next = STOP;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_time_counter_gen.sv
// Scoreboard bench: a wrapping and a saturating counter share stimulus and are
// checked against a linear-count reference model.
module tb_time_counter_gen;

  localparam int HI_MOD = 6;
  localparam int LO_MOD = 10;
  localparam int N_TOT  = HI_MOD * LO_MOD;

  typedef struct {
    int hi;
    int lo;
    int ovf;
    int run;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, back = 1'b0, clear = 1'b0, load = 1'b0;
  logic [2:0] load_high = '0;
  logic [3:0] load_low = '0;
  logic [1:0] run_toggle = '0;

  logic [2:0] hv0, hv1;
  logic [3:0] lv0, lv1;
  logic       ovf0, ovf1, run0, run1;

  int   checks = 0;
  int   errors = 0;
  int   mt[2];
  bit   mrun[2];
  bit   movf[2];
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  time_counter_gen dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .back(back), .run_toggle(run_toggle[0]),
    .clear(clear), .load(load), .load_high(load_high), .load_low(load_low),
    .high_val(hv0), .low_val(lv0), .ovf(ovf0), .running(run0)
  );

  time_counter_gen #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .back(back), .run_toggle(run_toggle[1]),
    .clear(clear), .load(load), .load_high(load_high), .load_low(load_low),
    .high_val(hv1), .low_val(lv1), .ovf(ovf1), .running(run1)
  );

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pair of digits is one count 0..N_TOT-1.
  task automatic model_step(input int d, input bit tk, input bit bk, input bit clr,
                            input bit ld, input int lh, input int ll, input bit tog);
    bit bound;
    bit stop_now;
    stop_now = 1'b0;
    movf[d]  = 1'b0;
    if (clr) begin
      mt[d] = 0;
    end else if (ld) begin
      mt[d] = ((lh >= HI_MOD) ? HI_MOD - 1 : lh) * LO_MOD + ((ll >= LO_MOD) ? LO_MOD - 1 : ll);
    end else if (tk && mrun[d]) begin
      bound = bk ? (mt[d] == 0) : (mt[d] == N_TOT - 1);
      if (bound) begin
        movf[d] = 1'b1;
        if (d == 1) stop_now = 1'b1;
        else        mt[d] = bk ? N_TOT - 1 : 0;
      end else begin
        mt[d] = bk ? mt[d] - 1 : mt[d] + 1;
      end
    end
    if (tog)      mrun[d] = !mrun[d];
    if (stop_now) mrun[d] = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mt[d] = 0; mrun[d] = 1'b0; movf[d] = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input bit tk, input bit bk, input bit clr, input bit ld,
                                input logic [2:0] lh, input logic [3:0] ll,
                                input logic [1:0] tog);
    @(negedge clk);
    tick = tk; back = bk; clear = clr; load = ld;
    load_high = lh; load_low = ll; run_toggle = tog;
    model_step(0, tk, bk, clr, ld, int'(lh), int'(ll), tog[0]);
    model_step(1, tk, bk, clr, ld, int'(lh), int'(ll), tog[1]);
    q0.push_back('{mt[0] / LO_MOD, mt[0] % LO_MOD, int'(movf[0]), int'(mrun[0])});
    q1.push_back('{mt[1] / LO_MOD, mt[1] % LO_MOD, int'(movf[1]), int'(mrun[1])});
  endtask

  task automatic set_run(input bit want);
    logic [1:0] tog;
    tog = {mrun[1] != want, mrun[0] != want};
    if (tog != 2'b00) apply_stimulus(0, 0, 0, 0, 3'd0, 4'd0, tog);
  endtask

  task automatic check_direct(input string tag);
    check_output({tag, "_wrap_high"}, int'(hv0), 0);
    check_output({tag, "_wrap_low"},  int'(lv0), 0);
    check_output({tag, "_wrap_ovf"},  int'(ovf0), 0);
    check_output({tag, "_wrap_run"},  int'(run0), 0);
    check_output({tag, "_sat_high"},  int'(hv1), 0);
    check_output({tag, "_sat_low"},   int'(lv1), 0);
    check_output({tag, "_sat_ovf"},   int'(ovf1), 0);
    check_output({tag, "_sat_run"},   int'(run1), 0);
  endtask

  // Monitor: outputs are compared one step after each stimulus cycle.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check_output("wrap_high", int'(hv0), e0.hi);
      check_output("wrap_low",  int'(lv0), e0.lo);
      check_output("wrap_ovf",  int'(ovf0), e0.ovf);
      check_output("wrap_run",  int'(run0), e0.run);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check_output("sat_high", int'(hv1), e1.hi);
      check_output("sat_low",  int'(lv1), e1.lo);
      check_output("sat_ovf",  int'(ovf1), e1.ovf);
      check_output("sat_run",  int'(run1), e1.run);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    model_reset();
    #3;
    check_direct("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Sixty up-ticks from 0:0 through the top bound.
    set_run(1'b1);
    for (int i = 0; i < 60; i++) apply_stimulus(1, 0, 0, 0, 3'd0, 4'd0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 3'd0, 4'd0, 2'b00);

    // Down wrap at 0:0, then a plain borrow from 1:0.
    apply_stimulus(0, 1, 0, 1, 3'd0, 4'd0, 2'b00);
    set_run(1'b1);
    apply_stimulus(1, 1, 0, 0, 3'd0, 4'd0, 2'b00);
    apply_stimulus(0, 1, 0, 1, 3'd1, 4'd0, 2'b00);
    set_run(1'b1);
    apply_stimulus(1, 1, 0, 0, 3'd0, 4'd0, 2'b00);

    // Approach the top bound from 5:8 with three ticks.
    apply_stimulus(0, 0, 0, 1, 3'd5, 4'd8, 2'b00);
    set_run(1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 0, 3'd0, 4'd0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 3'd0, 4'd0, 2'b00);

    // Priority: clear beats load beats tick; oversized preset clamps.
    set_run(1'b1);
    apply_stimulus(1, 0, 1, 1, 3'd3, 4'd4, 2'b00);
    apply_stimulus(0, 0, 0, 1, 3'd7, 4'd12, 2'b00);

    // STOP gating and a toggle coinciding with a tick.
    set_run(1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 3'd0, 4'd0, 2'b00);
    apply_stimulus(1, 1, 0, 0, 3'd0, 4'd0, 2'b11);
    apply_stimulus(1, 1, 0, 0, 3'd0, 4'd0, 2'b00);

    // Randomised traffic, including toggles coinciding with bound ticks.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(bit'($urandom_range(1)), bit'($urandom_range(1)),
                     ($urandom_range(31) == 0), ($urandom_range(15) == 0),
                     3'($urandom_range(7)), 4'($urandom_range(15)),
                     {($urandom_range(11) == 0), ($urandom_range(11) == 0)});
    end

    // Asynchronous reset in the middle of a running count at 3:7.
    apply_stimulus(0, 0, 0, 1, 3'd3, 4'd6, 2'b00);
    set_run(1'b1);
    apply_stimulus(1, 0, 0, 0, 3'd0, 4'd0, 2'b00);
    @(posedge clk);
    #2;
    tick = 0; back = 0; clear = 0; load = 0; run_toggle = 2'b00;
    rst = 1'b0;
    #1;
    check_direct("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 0, 3'd0, 4'd0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 3'd0, 4'd0, 2'b00);
    @(posedge clk);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
